// File: rtl/fetch_stage_pkg.sv
// Shared core definitions: immediate classes and RV32 opcodes used by fetch and
// by the downstream sign extender.
package fetch_stage_pkg;

  typedef enum logic [2:0] {
    IMM_NONE = 3'b000,
    IMM_I    = 3'b001,
    IMM_B    = 3'b010,
    IMM_U    = 3'b011,
    IMM_J    = 3'b100,
    IMM_S    = 3'b101
  } imm_t;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  typedef enum logic {F_IDLE, F_WAIT} fstate_t;

  function automatic imm_t imm_of(input logic [6:0] op);
    case (op)
      OP_IMM, OP_LOAD, OP_JALR: imm_of = IMM_I;
      OP_BRANCH:                imm_of = IMM_B;
      OP_LUI, OP_AUIPC:         imm_of = IMM_U;
      OP_JAL:                   imm_of = IMM_J;
      OP_STORE:                 imm_of = IMM_S;
      default:                  imm_of = IMM_NONE;
    endcase
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: instruction-memory request/response, redirect, and decode handoff.
interface fetch_stage_if;
  import fetch_stage_pkg::*;

  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  imm_t        imm_type;

  modport master (
    output imem_req_valid, imem_addr, instr_valid, instr_out, pc_out, imm_type,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc,
           instr_ready
  );

  modport slave (
    input  imem_req_valid, imem_addr, instr_valid, instr_out, pc_out, imm_type,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc,
           instr_ready
  );
endinterface

// File: rtl/fetch_stage_fifo.sv
// Small flushable FIFO holding {pc, instr} pairs between fetch and decode.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_empty,
  output logic [CW-1:0]    o_count
);
  logic [DEPTH-1:0][WIDTH-1:0] r_mem;
  logic [AW-1:0]               r_rd, r_wr;
  logic [CW-1:0]               r_cnt;
  logic                        w_pop, w_push;

  // A push into a full FIFO is accepted only when the head leaves in the same cycle.
  assign w_pop  = i_pop & ~o_empty;
  assign w_push = i_push & ((r_cnt != CW'(DEPTH)) | w_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem <= '0;
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
    end else if (i_flush) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= i_wdata;
        r_wr        <= (r_wr == AW'(DEPTH - 1)) ? '0 : r_wr + AW'(1);
      end
      if (w_pop) r_rd <= (r_rd == AW'(DEPTH - 1)) ? '0 : r_rd + AW'(1);
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end

  assign o_rdata = r_mem[r_rd];
  assign o_empty = (r_cnt == '0);
  assign o_count = r_cnt;
endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC sequencing, single-outstanding imem requests, epoch-based
// squashing of stale responses, and a 2-deep buffer toward decode.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst,
  fetch_stage_if.master bus
);
  fstate_t     r_state, w_state_nxt;
  logic [31:0] r_pc, r_req_pc;
  logic        r_epoch, r_req_epoch;
  logic [1:0]  r_inflight;
  logic        w_old, w_rsp_ours, w_push, w_pop, w_accept, w_empty;
  logic [1:0]  w_cnt, w_load;
  logic [63:0] w_head;

  // Responses owed to requests issued before a reset arrive first (in order);
  // anything beyond our own single outstanding request is one of those.
  assign w_old      = r_inflight > {1'b0, r_state == F_WAIT};
  assign w_rsp_ours = bus.imem_rsp_valid & (r_state == F_WAIT) & ~w_old;
  assign w_push     = w_rsp_ours & (r_req_epoch == r_epoch) & ~bus.redirect_valid;
  assign w_pop      = bus.instr_ready & ~w_empty & ~bus.redirect_valid;

  // Buffer slots already spoken for once this cycle's pop retires.
  assign w_load = w_cnt - {1'b0, w_pop} + {1'b0, r_state == F_WAIT};

  assign bus.imem_req_valid = ~rst & ~bus.redirect_valid &
                              ((r_state == F_IDLE) | w_rsp_ours) & (w_load < 2'd2);
  assign bus.imem_addr      = r_pc;
  assign w_accept           = bus.imem_req_valid & bus.imem_req_ready;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      F_IDLE: if (w_accept) w_state_nxt = F_WAIT;
      F_WAIT: if (w_rsp_ours && !w_accept) w_state_nxt = F_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= F_IDLE;
      r_pc        <= RESET_PC;
      r_req_pc    <= '0;
      r_epoch     <= 1'b0;
      r_req_epoch <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (bus.redirect_valid) begin
        r_pc    <= {bus.redirect_pc[31:2], 2'b00};
        r_epoch <= ~r_epoch;
      end else if (w_accept) begin
        r_pc <= r_pc + 32'd4;
      end
      if (w_accept) begin
        r_req_pc    <= r_pc;
        r_req_epoch <= r_epoch;
      end
    end
  end

  // Intentionally outside reset: it must remember requests still in memory across rst.
  always_ff @(posedge clk)
    r_inflight <= r_inflight + {1'b0, w_accept} -
                  {1'b0, bus.imem_rsp_valid & (r_inflight != 2'd0)};

  fetch_fifo #(.DEPTH(2), .WIDTH(64)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_flush (bus.redirect_valid),
    .i_push  (w_push),
    .i_wdata ({r_req_pc, bus.imem_rsp_data}),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_empty (w_empty),
    .o_count (w_cnt)
  );

  assign bus.instr_valid = ~w_empty;
  assign bus.instr_out   = w_empty ? 32'h0 : w_head[31:0];
  assign bus.pc_out      = w_empty ? 32'h0 : w_head[63:32];
  assign bus.imm_type    = w_empty ? IMM_NONE : imm_of(w_head[6:0]);
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with an in-order latency memory and a queue model
// of the instruction stream decode should see.
module tb_fetch_stage;
  localparam logic [31:0] RPC = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  fetch_stage_if bus();
  fetch_stage #(.RESET_PC(RPC)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int due; int gen; int rgen; } pend_t;
  typedef struct { logic [31:0] pc; logic [31:0] w; } ent_t;

  pend_t pend[$];
  ent_t  mq[$];
  int n_chk = 0, n_pass = 0;
  int cyc = 0, gen = 0, rgen = 0, lat = 1;
  logic [31:0] m_pc = RPC;
  bit rr_toggle = 0;
  bit nxt_rst = 1, nxt_redir = 0, nxt_ready = 1;
  logic [31:0] nxt_rpc = 32'h0;
  logic s_iv, s_rv;
  logic [31:0] s_pc, s_instr, s_addr;
  logic [2:0] s_imm;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [6:0] op;
    if (a == 32'h0) return 32'h00500093;
    if (a == 32'h4) return 32'h00000463;
    case ((a >> 2) % 10)
      0: op = 7'h13;  1: op = 7'h03;  2: op = 7'h67;  3: op = 7'h63;  4: op = 7'h37;
      5: op = 7'h17;  6: op = 7'h6F;  7: op = 7'h23;  8: op = 7'h33;  default: op = 7'h7F;
    endcase
    return {a[26:2] ^ 25'h1A55A5A, op};
  endfunction

  function automatic logic [2:0] exp_imm(input logic [6:0] op);
    if (op inside {7'b0010011, 7'b0000011, 7'b1100111}) return 3'b001;
    if (op == 7'b1100011)                               return 3'b010;
    if (op inside {7'b0110111, 7'b0010111})             return 3'b011;
    if (op == 7'b1101111)                               return 3'b100;
    if (op == 7'b0100011)                               return 3'b101;
    return 3'b000;
  endfunction

  function automatic int live_cnt();
    int n = 0;
    foreach (pend[i]) if (pend[i].rgen == rgen) n++;
    return n;
  endfunction

  // Per-cycle comparison of DUT outputs against the model, then model advance.
  task automatic compare_and_update();
    pend_t d;
    ent_t  e;
    bit got = 0;
    bit acc = s_rv & bus.imem_req_ready;
    if (rst) begin
      chk("rst_instr_valid", s_iv, 0);
      chk("rst_req_valid", s_rv, 0);
      chk("rst_instr_out", s_instr, 0);
      chk("rst_pc_out", s_pc, 0);
      chk("rst_imm_type", s_imm, 0);
      if (bus.imem_rsp_valid) void'(pend.pop_front());
      mq.delete(); gen++; rgen++; m_pc = RPC;
      return;
    end
    chk("instr_valid", s_iv, mq.size() > 0);
    if (mq.size() > 0) begin
      chk("pc_out", s_pc, mq[0].pc);
      chk("instr_out", s_instr, mq[0].w);
      chk("imm_type", s_imm, exp_imm(mq[0].w[6:0]));
    end else chk("imm_type_idle", s_imm, 0);
    if (bus.redirect_valid) chk("req_during_redirect", s_rv, 0);
    if (bus.imem_rsp_valid) begin d = pend.pop_front(); got = 1; end
    if (acc) begin
      chk("req_addr", s_addr, m_pc);
      chk("one_outstanding", live_cnt(), 0);
    end
    if (bus.redirect_valid) begin
      mq.delete(); gen++; m_pc = {bus.redirect_pc[31:2], 2'b00};
    end else begin
      if (bus.instr_ready && mq.size() > 0) void'(mq.pop_front());
      if (got && d.gen == gen) begin e.pc = d.addr; e.w = mem_word(d.addr); mq.push_back(e); end
      if (acc) m_pc = m_pc + 32'd4;
    end
    if (acc) begin
      chk("credit", (mq.size() + 1) <= 2, 1);
      d.addr = s_addr; d.due = cyc + lat; d.gen = gen; d.rgen = rgen;
      pend.push_back(d);
    end
  endtask

  task automatic step();
    @(negedge clk);
    rst                = nxt_rst;
    bus.redirect_valid = nxt_redir;
    bus.redirect_pc    = nxt_rpc;
    bus.instr_ready    = nxt_ready;
    nxt_redir          = 0;
    bus.imem_req_ready = rr_toggle ? cyc[0] : 1'b1;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = mem_word(pend[0].addr);
    end else begin
      bus.imem_rsp_valid = 1'b0; bus.imem_rsp_data = 32'hDEAD_BEEF;
    end
    #4;
    s_iv = bus.instr_valid; s_rv = bus.imem_req_valid; s_addr = bus.imem_addr;
    s_pc = bus.pc_out; s_instr = bus.instr_out; s_imm = bus.imm_type;
    compare_and_update();
    cyc++;
  endtask

  task automatic wait_valid(input string nm, input int maxc);
    int k = 0;
    do begin step(); k++; end while (!s_iv && k < maxc);
    chk({nm, "_valid"}, s_iv, 1);
  endtask

  task automatic wait_outstanding(input string nm, input int maxc);
    int k = 0;
    while (live_cnt() == 0 && k < maxc) begin step(); k++; end
    chk({nm, "_outstanding"}, live_cnt() > 0, 1);
  endtask

  initial begin
    logic [31:0] held;
    bus.imem_req_ready = 0; bus.imem_rsp_valid = 0; bus.imem_rsp_data = 0;
    bus.redirect_valid = 0; bus.redirect_pc = 0; bus.instr_ready = 0;
    #1 rst = 1'b1;
    step(); step();

    // Reset release, latency 1, decode always ready
    nxt_rst = 0; lat = 1;
    step();
    chk("first_req_valid", s_rv, 1);
    chk("first_req_addr", s_addr, RPC);
    wait_valid("t034", 10);
    chk("seq0_pc", s_pc, 32'h0);
    chk("seq0_instr", s_instr, 32'h00500093);
    chk("seq0_imm", s_imm, 3'b001);
    step();
    chk("seq1_valid", s_iv, 1);
    chk("seq1_pc", s_pc, 32'h4);
    chk("seq1_imm", s_imm, 3'b010);
    step();
    chk("seq2_valid", s_iv, 1);
    chk("seq2_pc", s_pc, 32'h8);
    repeat (6) step();

    // Decode stalls for 5 cycles
    nxt_ready = 0;
    step(); held = s_pc;
    repeat (4) step();
    chk("stall_req_off", s_rv, 0);
    chk("stall_valid", s_iv, 1);
    chk("stall_held_pc", s_pc, held);
    nxt_ready = 1;
    repeat (8) step();

    // Redirect while a request is outstanding
    lat = 3;
    wait_outstanding("t037", 10);
    nxt_redir = 1; nxt_rpc = 32'h0000_0103;
    step();
    chk("redirect_next_invalid_req", s_rv, 0);
    wait_valid("t037", 20);
    chk("redir_pc", s_pc, 32'h100);
    repeat (5) step();

    // Latency 3 with toggling request-ready and intermittent decode-ready
    rr_toggle = 1;
    for (int i = 0; i < 40; i++) begin nxt_ready = (i % 3 != 0); step(); end
    rr_toggle = 0; nxt_ready = 1;
    repeat (10) step();

    // PC wrap at the top of the address space
    lat = 1;
    nxt_redir = 1; nxt_rpc = 32'hFFFF_FFF8;
    step();
    step();
    chk("post_redirect_empty", s_iv, 0);
    wait_valid("wrap", 20);
    chk("wrap0_pc", s_pc, 32'hFFFF_FFF8);
    step();
    chk("wrap1_pc", s_pc, 32'hFFFF_FFFC);
    step();
    chk("wrap2_pc", s_pc, 32'h0);
    chk("wrap2_instr", s_instr, 32'h00500093);
    repeat (4) step();

    // Reset mid-request; the late response must not reach decode
    lat = 5;
    wait_outstanding("t039", 10);
    nxt_rst = 1;
    step();
    nxt_rst = 0;
    step();
    chk("rel_req_valid", s_rv, 1);
    chk("rel_req_addr", s_addr, RPC);
    wait_valid("t039", 20);
    chk("rst_first_pc", s_pc, RPC);
    chk("rst_first_instr", s_instr, 32'h00500093);
    repeat (20) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_chk);
    $fatal(1);
  end
endmodule
